// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: head byte, valid/ready and FIFO occupancy.
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  logic [7:0]                  rx_byte;
  logic                        rx_valid;
  logic                        rx_ready;
  logic [$clog2(FIFO_DEPTH):0] rx_count;

  modport master (output rx_byte, output rx_valid, output rx_count, input rx_ready);
  modport slave  (input rx_byte, input rx_valid, input rx_count, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-point mid-bit majority sampling and a show-ahead
// receive FIFO drained over a valid/ready handshake.
//
// state     | meaning
// WAIT_HIGH | after reset or a framing error; wait for the line to idle high
// IDLE      | line high, looking for a start-bit falling edge
// START     | qualifying the start bit (false start returns to IDLE)
// DATA      | shifting in 8 data bits, LSB first
// STOP      | checking the stop bit; leaves mid-bit so back-to-back frames work
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_pin,
  uart_rx_if.master rx_if,
  output logic      rx_busy,
  output logic      frame_error,
  output logic      overrun
);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic            frame_error_q, frame_error_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     occ_q, occ_d;

  logic line, wrap, decide, maj, push, pop, full, wr_en;

  assign line   = sync_q[1];
  assign wrap   = (cnt_q == CNT_LAST);
  assign decide = (cnt_q == CNT_DEC);
  // The third sample is the live line value at the decision count.
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
  assign sync_d = {sync_q[0], rx_pin};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_HIGH;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_HIGH: if (line) state_d = IDLE;
      IDLE:      if (!line) state_d = START;
      START:     if (decide && maj) state_d = IDLE;
                 else if (wrap) state_d = DATA;
      DATA:      if (wrap && bit_q == 3'd7) state_d = STOP;
      STOP:      if (decide) state_d = maj ? IDLE : WAIT_HIGH;
      default:   state_d = WAIT_HIGH;
    endcase
  end

  // FSM outputs: bit timing, sampling, shifting and stop-bit verdict.
  always_comb begin
    cnt_d         = '0;
    samp_d        = samp_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    push          = 1'b0;
    frame_error_d = 1'b0;
    rx_busy       = 1'b0;
    if (state_q == START || state_q == DATA || state_q == STOP) begin
      rx_busy = 1'b1;
      cnt_d   = wrap ? '0 : cnt_q + CNT_ONE;
      if (cnt_q == CNT_S0) samp_d[0] = line;
      if (cnt_q == CNT_S1) samp_d[1] = line;
    end
    case (state_q)
      START: bit_d = '0;
      DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (wrap)   bit_d   = bit_q + 3'd1;
      end
      STOP: begin
        if (decide) begin
          push          = maj;
          frame_error_d = ~maj;
        end
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a push when the head is popped.
  always_comb begin
    pop       = rx_if.rx_valid & rx_if.rx_ready;
    full      = (occ_q == OCC_FULL);
    wr_en     = push & (~full | pop);
    overrun_d = push & full & ~pop;
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    occ_d     = occ_q;
    if (wr_en) begin
      mem_d[wr_q] = shift_q;
      wr_d        = wr_q + PTR_ONE;
    end
    if (pop) rd_d = rd_q + PTR_ONE;
    if (wr_en && !pop)      occ_d = occ_q + OCC_ONE;
    else if (!wr_en && pop) occ_d = occ_q - OCC_ONE;
  end

  // Datapath and FIFO registers; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q        <= 2'b11;
      cnt_q         <= '0;
      samp_q        <= '0;
      shift_q       <= '0;
      bit_q         <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      mem_q         <= '{default: '0};
      wr_q          <= '0;
      rd_q          <= '0;
      occ_q         <= '0;
    end else begin
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      samp_q        <= samp_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      mem_q         <= mem_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      occ_q         <= occ_d;
    end
  end

  assign rx_if.rx_byte  = mem_q[rd_q];
  assign rx_if.rx_valid = (occ_q != '0);
  assign rx_if.rx_count = occ_q;
  assign frame_error    = frame_error_q;
  assign overrun        = overrun_q;
endmodule
